// File: rtl/frv_mdu_arbiter.sv
// frv_mdu_arbiter: shares one multi-cycle multiply/divide unit between two
// requesters. Requester 0 is the execute-stage integer pipe. Requester 1 is a
// secondary co-unit.
//
// The block grants ownership, steers the owner's operands to the unit, routes
// the result back, and flushes the unit on completion or abort. Grant and ready
// are combinational. Only the ownership state (and optionally the last-grant
// bit) is registered. Owner operands must stay stable while the owner is busy.
//
// Build option FRV_MDU_ARB_RR_EN:
//   defined   - round-robin on contention, using the last granted requester
//   undefined - fixed priority, requester 0 always wins contention
module frv_mdu_arbiter #(
    parameter int XLEN = 32,
    parameter int OPW  = 8
) (
    input  logic            g_clk,
    input  logic            g_resetn,

    input  logic            r0_valid,
    input  logic            r0_flush,
    input  logic [OPW-1:0]  r0_op,
    input  logic [XLEN-1:0] r0_rs1,
    input  logic [XLEN-1:0] r0_rs2,
    output logic            r0_ready,
    output logic [XLEN-1:0] r0_rd,

    input  logic            r1_valid,
    input  logic            r1_flush,
    input  logic [OPW-1:0]  r1_op,
    input  logic [XLEN-1:0] r1_rs1,
    input  logic [XLEN-1:0] r1_rs2,
    output logic            r1_ready,
    output logic [XLEN-1:0] r1_rd,

    output logic            mdu_valid,
    output logic            mdu_flush,
    output logic [OPW-1:0]  mdu_op,
    output logic [XLEN-1:0] mdu_rs1,
    output logic [XLEN-1:0] mdu_rs2,
    input  logic            mdu_ready,
    input  logic [XLEN-1:0] mdu_rd
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic elig0;
    logic elig1;
    logic grant0;
    logic grant1;

    assign elig0 = r0_valid && !r0_flush;
    assign elig1 = r1_valid && !r1_flush;

`ifdef FRV_MDU_ARB_RR_EN
    logic last_reg;
    logic last_next;

    // On contention, grant the requester that was not served last.
    assign grant1 = elig1 && (!elig0 || !last_reg);
`else
    // Requester 1 is served only when requester 0 is not eligible.
    assign grant1 = elig1 && !elig0;
`endif
    assign grant0 = elig0 && !grant1;

    // Grant, steering, completion/abort handling and next-state selection.
    always_comb begin
        state_next = state_reg;
`ifdef FRV_MDU_ARB_RR_EN
        last_next  = last_reg;
`endif
        mdu_valid  = 1'b0;
        mdu_flush  = 1'b0;
        mdu_op     = '0;
        mdu_rs1    = '0;
        mdu_rs2    = '0;
        r0_ready   = 1'b0;
        r0_rd      = '0;
        r1_ready   = 1'b0;
        r1_rd      = '0;
        if (!g_resetn) begin
            // Reset holds the unit flushed and discards any in-flight result.
            mdu_flush  = 1'b1;
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant0) begin
                        mdu_valid  = 1'b1;
                        mdu_op     = r0_op;
                        mdu_rs1    = r0_rs1;
                        mdu_rs2    = r0_rs2;
                        state_next = BUSY0;
`ifdef FRV_MDU_ARB_RR_EN
                        last_next  = 1'b0;
`endif
                    end else if (grant1) begin
                        mdu_valid  = 1'b1;
                        mdu_op     = r1_op;
                        mdu_rs1    = r1_rs1;
                        mdu_rs2    = r1_rs2;
                        state_next = BUSY1;
`ifdef FRV_MDU_ARB_RR_EN
                        last_next  = 1'b1;
`endif
                    end
                end
                BUSY0: begin
                    mdu_valid = 1'b1;
                    mdu_op    = r0_op;
                    mdu_rs1   = r0_rs1;
                    mdu_rs2   = r0_rs2;
                    // Abort takes precedence over a same-cycle completion.
                    if (r0_flush || !r0_valid) begin
                        mdu_flush  = 1'b1;
                        state_next = IDLE;
                    end else if (mdu_ready) begin
                        r0_ready   = 1'b1;
                        r0_rd      = mdu_rd;
                        mdu_flush  = 1'b1;
                        state_next = IDLE;
                    end
                end
                BUSY1: begin
                    mdu_valid = 1'b1;
                    mdu_op    = r1_op;
                    mdu_rs1   = r1_rs1;
                    mdu_rs2   = r1_rs2;
                    if (r1_flush || !r1_valid) begin
                        mdu_flush  = 1'b1;
                        state_next = IDLE;
                    end else if (mdu_ready) begin
                        r1_ready   = 1'b1;
                        r1_rd      = mdu_rd;
                        mdu_flush  = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Ownership state. The last-grant bit resets to 1 so requester 0 wins the
    // first contention.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_reg <= IDLE;
`ifdef FRV_MDU_ARB_RR_EN
            last_reg  <= 1'b1;
`endif
        end else begin
            state_reg <= state_next;
`ifdef FRV_MDU_ARB_RR_EN
            last_reg  <= last_next;
`endif
        end
    end

endmodule

// File: tb/tb_frv_mdu_arbiter.sv
// Directed testbench for frv_mdu_arbiter. The bench plays the role of the
// shared unit by driving mdu_ready/mdu_rd. Inputs change 1 ns after the rising
// edge, and outputs are checked 1 ns later, well away from the edge.
module tb_frv_mdu_arbiter;

    localparam int XLEN = 32;
    localparam int OPW  = 8;

    logic            g_clk = 1'b0;
    logic            g_resetn;
    logic            r0_valid, r0_flush, r1_valid, r1_flush;
    logic [OPW-1:0]  r0_op, r1_op;
    logic [XLEN-1:0] r0_rs1, r0_rs2, r1_rs1, r1_rs2;
    logic            r0_ready, r1_ready;
    logic [XLEN-1:0] r0_rd, r1_rd;
    logic            mdu_valid, mdu_flush, mdu_ready;
    logic [OPW-1:0]  mdu_op;
    logic [XLEN-1:0] mdu_rs1, mdu_rs2, mdu_rd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 g_clk = ~g_clk;

    frv_mdu_arbiter #(.XLEN(XLEN), .OPW(OPW)) dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .r0_valid  (r0_valid),
        .r0_flush  (r0_flush),
        .r0_op     (r0_op),
        .r0_rs1    (r0_rs1),
        .r0_rs2    (r0_rs2),
        .r0_ready  (r0_ready),
        .r0_rd     (r0_rd),
        .r1_valid  (r1_valid),
        .r1_flush  (r1_flush),
        .r1_op     (r1_op),
        .r1_rs1    (r1_rs1),
        .r1_rs2    (r1_rs2),
        .r1_ready  (r1_ready),
        .r1_rd     (r1_rd),
        .mdu_valid (mdu_valid),
        .mdu_flush (mdu_flush),
        .mdu_op    (mdu_op),
        .mdu_rs1   (mdu_rs1),
        .mdu_rs2   (mdu_rs2),
        .mdu_ready (mdu_ready),
        .mdu_rd    (mdu_rd)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance to 1 ns past the next rising edge, where new inputs are applied.
    task automatic next_cycle();
        @(posedge g_clk);
        #1;
    endtask

    // Let the combinational outputs settle before checking.
    task automatic settle();
        #1;
    endtask

    initial begin
        logic [OPW-1:0] exp_op;
        g_resetn = 1'b0;
        r0_valid = 1'b1; r0_flush = 1'b0; r0_op = 8'h01; r0_rs1 = 32'd7; r0_rs2 = 32'd6;
        r1_valid = 1'b0; r1_flush = 1'b0; r1_op = 8'h00; r1_rs1 = 32'd0; r1_rs2 = 32'd0;
        mdu_ready = 1'b0; mdu_rd = 32'd0;

        // Reset: all outputs 0 except mdu_flush, even with a request present.
        next_cycle(); settle();
        chk("rst_flush", mdu_flush, 1);
        chk("rst_valid", mdu_valid, 0);
        chk("rst_op", mdu_op, 0);
        chk("rst_rs1", mdu_rs1, 0);
        chk("rst_ready0", r0_ready, 0);
        $display("reset cycle: flush=%0d valid=%0d", mdu_flush, mdu_valid);

        // Single requester: mul 7*6, unit ready on the third cycle after the grant.
        next_cycle(); g_resetn = 1'b1; settle();
        chk("single_grant_valid", mdu_valid, 1);
        chk("single_grant_op", mdu_op, 8'h01);
        chk("single_grant_rs1", mdu_rs1, 7);
        chk("single_grant_rs2", mdu_rs2, 6);
        chk("single_grant_flush", mdu_flush, 0);
        next_cycle(); settle();
        chk("single_busy_ready", r0_ready, 0);
        next_cycle(); settle();
        chk("single_busy2_ready", r0_ready, 0);
        next_cycle(); mdu_ready = 1'b1; mdu_rd = 32'd42; settle();
        chk("single_done_ready", r0_ready, 1);
        chk("single_done_rd", r0_rd, 42);
        chk("single_done_flush", mdu_flush, 1);
        $display("single: r0_ready=%0d r0_rd=%0d", r0_ready, r0_rd);
        next_cycle(); r0_valid = 1'b0; mdu_ready = 1'b0; settle();
        chk("single_idle_valid", mdu_valid, 0);
        chk("single_idle_ready", r0_ready, 0);
        chk("single_idle_rd", r0_rd, 0);

        // Contention from reset: r0 div 100/7, r1 rem 100/7.
        next_cycle(); g_resetn = 1'b0;
        r0_valid = 1'b1; r0_op = 8'h10; r0_rs1 = 32'd100; r0_rs2 = 32'd7;
        r1_valid = 1'b1; r1_op = 8'h40; r1_rs1 = 32'd100; r1_rs2 = 32'd7;
        next_cycle(); g_resetn = 1'b1; settle();
        chk("cont_grant0_op", mdu_op, 8'h10);
        chk("cont_grant0_rs1", mdu_rs1, 100);
        // A non-owner flush must not disturb the owner.
        next_cycle(); r1_flush = 1'b1; settle();
        chk("cont_busy_r1ready", r1_ready, 0);
        chk("cont_busy_op", mdu_op, 8'h10);
        chk("cont_busy_flush", mdu_flush, 0);
        next_cycle(); r1_flush = 1'b0; mdu_ready = 1'b1; mdu_rd = 32'd14; settle();
        chk("cont_done0_ready", r0_ready, 1);
        chk("cont_done0_rd", r0_rd, 14);
        chk("cont_done0_r1ready", r1_ready, 0);
        $display("contention r0: rd=%0d", r0_rd);
        next_cycle(); r0_valid = 1'b0; mdu_ready = 1'b0; settle();
        chk("cont_grant1_valid", mdu_valid, 1);
        chk("cont_grant1_op", mdu_op, 8'h40);
        next_cycle(); mdu_ready = 1'b1; mdu_rd = 32'd2; settle();
        chk("cont_done1_ready", r1_ready, 1);
        chk("cont_done1_rd", r1_rd, 2);
        chk("cont_done1_r0ready", r0_ready, 0);
        $display("contention r1: rd=%0d", r1_rd);
        next_cycle(); r1_valid = 1'b0; mdu_ready = 1'b0; settle();
        chk("cont_idle_valid", mdu_valid, 0);

        // Repeated contention: both requesters keep requesting for 4 operations.
        r0_valid = 1'b1; r0_op = 8'h01; r0_rs1 = 32'd3; r0_rs2 = 32'd4;
        r1_valid = 1'b1; r1_op = 8'h02; r1_rs1 = 32'd5; r1_rs2 = 32'd6;
        for (int i = 0; i < 4; i++) begin
`ifdef FRV_MDU_ARB_RR_EN
            exp_op = (i % 2 == 0) ? 8'h01 : 8'h02;
`else
            exp_op = 8'h01;
`endif
            next_cycle(); mdu_ready = 1'b0; settle();
            chk($sformatf("rep%0d_grant_op", i), mdu_op, exp_op);
            next_cycle(); mdu_ready = 1'b1; mdu_rd = 32'(100 + i); settle();
            chk($sformatf("rep%0d_r0ready", i), r0_ready, (exp_op == 8'h01) ? 1 : 0);
            chk($sformatf("rep%0d_r1ready", i), r1_ready, (exp_op == 8'h02) ? 1 : 0);
            $display("repeat %0d: op=%0h r0_ready=%0d r1_ready=%0d", i, mdu_op, r0_ready, r1_ready);
        end

        // Abort: r0 flushes two cycles into BUSY0 while r1 waits.
        next_cycle(); mdu_ready = 1'b0; r1_valid = 1'b0;
        r0_op = 8'h01; r0_rs1 = 32'd3; r0_rs2 = 32'd5; settle();
        chk("abort_grant_op", mdu_op, 8'h01);
        next_cycle(); r1_valid = 1'b1; r1_op = 8'h20; r1_rs1 = 32'd9; r1_rs2 = 32'd4; settle();
        chk("abort_busy_op", mdu_op, 8'h01);
        chk("abort_busy_r1ready", r1_ready, 0);
        next_cycle(); r0_flush = 1'b1; settle();
        chk("abort_flush", mdu_flush, 1);
        chk("abort_r0ready", r0_ready, 0);
        $display("abort: flush=%0d r0_ready=%0d", mdu_flush, r0_ready);
        next_cycle(); r0_flush = 1'b0; r0_valid = 1'b0; settle();
        chk("abort_next_op", mdu_op, 8'h20);
        chk("abort_next_rs1", mdu_rs1, 9);
        chk("abort_next_flush", mdu_flush, 0);

        // Abort and completion in the same BUSY1 cycle: abort wins.
        next_cycle(); mdu_ready = 1'b1; mdu_rd = 32'd2; r1_flush = 1'b1; settle();
        chk("simul_r1ready", r1_ready, 0);
        chk("simul_r1rd", r1_rd, 0);
        chk("simul_flush", mdu_flush, 1);
        $display("abort+done: r1_ready=%0d flush=%0d", r1_ready, mdu_flush);
        next_cycle(); r1_flush = 1'b0; mdu_ready = 1'b0; settle();
        chk("simul_regrant_op", mdu_op, 8'h20);

        // Reset during BUSY1 discards the result; contention then grants r0.
        next_cycle(); g_resetn = 1'b0; mdu_ready = 1'b1; mdu_rd = 32'd77;
        r0_valid = 1'b1; r0_op = 8'h01; r0_rs1 = 32'd11; r0_rs2 = 32'd12; settle();
        chk("midrst_r0ready", r0_ready, 0);
        chk("midrst_r1ready", r1_ready, 0);
        chk("midrst_flush", mdu_flush, 1);
        chk("midrst_valid", mdu_valid, 0);
        next_cycle(); g_resetn = 1'b1; mdu_ready = 1'b0; settle();
        chk("midrst_grant_op", mdu_op, 8'h01);
        chk("midrst_grant_rs1", mdu_rs1, 11);
        next_cycle(); mdu_ready = 1'b1; mdu_rd = 32'd123; settle();
        chk("midrst_done_r0ready", r0_ready, 1);
        chk("midrst_done_r0rd", r0_rd, 123);
        chk("midrst_done_r1ready", r1_ready, 0);
        $display("post-reset: r0_ready=%0d r0_rd=%0d", r0_ready, r0_rd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
